rob_flush_walker: RTL

- Consumes `flush`/`flush_pos` from the branch unit on a branch mispredict.
- Walks the reorder buffer backwards from the current tail to the entry after the mispredicted branch. It invalidates up to WALK_W entries per cycle.
- When the walk completes, it reloads the ROB tail and releases the front-end stall.
- Sits between the branch unit and the ROB/rename free-list logic.

---
 rtl/rob_flush_walker_pkg.sv | 20 ++
 rtl/rob_flush_walker_kill_lanes.sv | 27 ++
 rtl/rob_flush_walker.sv | 109 ++++++++++
 3 files changed

// File: rtl/rob_flush_walker_pkg.sv
// Shared types and helpers for the ROB mispredict flush walker.
package rob_flush_walker_pkg;

  localparam int ROB_PTR_W = 7;
  localparam int ROB_DEPTH = 2 ** (ROB_PTR_W - 1);

  typedef logic [ROB_PTR_W-1:0] rob_ptr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } walk_state_e;

  // Age of a pointer relative to the ROB head; the wrap bit makes this unambiguous.
  function automatic rob_ptr_t rob_age(input rob_ptr_t ptr, input rob_ptr_t head);
    return ptr - head;
  endfunction

endpackage

// File: rtl/rob_flush_walker_kill_lanes.sv
// Combinational kill-lane generator: strobes and indices for the next n entries below walk_ptr.
module rob_kill_lanes
  import rob_flush_walker_pkg::*;
#(
  parameter int PTR_W  = ROB_PTR_W,
  parameter int WALK_W = 4
) (
  input  logic [PTR_W-1:0]            walk_ptr,
  input  logic [PTR_W-1:0]            remaining,
  output logic [WALK_W-1:0]           kill_en,
  output logic [WALK_W*(PTR_W-1)-1:0] kill_idx,
  output logic [PTR_W-1:0]            n
);

  localparam int IDX_W = PTR_W - 1;

  assign n = (remaining < PTR_W'(WALK_W)) ? remaining : PTR_W'(WALK_W);

  for (genvar k = 0; k < WALK_W; k++) begin : g_lane
    logic [PTR_W-1:0] lane_ptr;
    assign lane_ptr                 = walk_ptr - PTR_W'(k + 1);
    assign kill_en[k]               = (PTR_W'(k) < n);
    // Idle lanes drive index 0 so the bus is quiet outside the walk.
    assign kill_idx[k*IDX_W +: IDX_W] = kill_en[k] ? lane_ptr[IDX_W-1:0] : '0;
  end

endmodule

// File: rtl/rob_flush_walker.sv
// Mispredict flush walker: squashes ROB entries younger than the branch, then restores the tail.
// Optional counters enabled by defining FLUSH_STATS_EN.
module rob_flush_walker
  import rob_flush_walker_pkg::*;
#(
  parameter int PTR_W  = ROB_PTR_W,
  parameter int WALK_W = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic [PTR_W-1:0]            flush_pos,
  input  logic [PTR_W-1:0]            rob_head,
  input  logic [PTR_W-1:0]            rob_tail,
  output logic [WALK_W-1:0]           kill_en,
  output logic [WALK_W*(PTR_W-1)-1:0] kill_idx,
  output logic                        tail_load,
  output logic [PTR_W-1:0]            new_tail,
  output logic                        stall_front,
  output logic                        flush_done,
  output logic                        busy
`ifdef FLUSH_STATS_EN
  ,
  output logic [15:0]                 stat_flushes,
  output logic [23:0]                 stat_squashed
`endif
);

  walk_state_e      state_q, state_d;
  logic [PTR_W-1:0] walk_ptr_q, target_q;
  logic [PTR_W-1:0] flush_tgt, remaining, lane_rem, n;
  logic             retarget;

  assign flush_tgt = flush_pos + PTR_W'(1);
  assign remaining = rob_age(walk_ptr_q, rob_head) - rob_age(target_q, rob_head);
  assign lane_rem  = (state_q == WALK) ? remaining : '0;

  // An older mispredict during the walk pulls the target back; younger ones are already covered.
  assign retarget  = (state_q == WALK) && flush &&
                     (rob_age(flush_tgt, rob_head) < rob_age(target_q, rob_head));

  rob_kill_lanes #(.PTR_W(PTR_W), .WALK_W(WALK_W)) u_lanes (
    .walk_ptr  (walk_ptr_q),
    .remaining (lane_rem),
    .kill_en   (kill_en),
    .kill_idx  (kill_idx),
    .n         (n)
  );

  always_comb begin
    state_d     = state_q;
    tail_load   = 1'b0;
    flush_done  = 1'b0;
    new_tail    = '0;
    busy        = (state_q != IDLE);
    stall_front = (state_q != IDLE) | flush;
    case (state_q)
      IDLE: if (flush) state_d = (rob_tail == flush_tgt) ? DONE : WALK;
      WALK: if (!retarget && (remaining == n)) state_d = DONE;
      DONE: begin
        tail_load  = 1'b1;
        flush_done = 1'b1;
        new_tail   = target_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      walk_ptr_q <= '0;
      target_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && flush) begin
        target_q   <= flush_tgt;
        walk_ptr_q <= rob_tail;
      end else if (state_q == WALK) begin
        walk_ptr_q <= walk_ptr_q - n;
        if (retarget) target_q <= flush_tgt;
      end
    end
  end

`ifdef FLUSH_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  function automatic logic [23:0] sat_add24(input logic [23:0] v, input logic [23:0] d);
    logic [24:0] s;
    s = {1'b0, v} + {1'b0, d};
    return s[24] ? '1 : s[23:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_flushes  <= '0;
      stat_squashed <= '0;
    end else begin
      if (flush_done) stat_flushes <= sat_inc16(stat_flushes);
      stat_squashed <= sat_add24(stat_squashed, 24'($countones(kill_en)));
    end
  end
`endif

endmodule
